reset_sequencer: RTL
====================

RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_DOMAINS, default 3, giving the number of staged reset outputs; legal range 1..16.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 14, giving the clock cycles all domains stay in reset after release begins; legal range 1..65535.
REQ-003 The block SHALL have parameter STAGE_GAP, default 4, giving the cycles between releases of consecutive domains; legal range 1..255.
REQ-004 The block SHALL have parameter SYNC_STAGES, default 2, giving the flop depth of the reset deassertion synchronizer; legal range 2..4.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port soft_req, input, 1 bit: software reset request, sampled every cycle.
REQ-008 The block SHALL have port ext_hold, input, 1 bit: while high, the sequencer stays in reset.
REQ-009 The block SHALL have port rst_n_out, output, NUM_DOMAINS bits: per-domain active-low resets, registered.
REQ-010 The block SHALL have port all_ready, output, 1 bit: high when every domain is released, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high in states ASSERT and RELEASE.
REQ-012 The block SHALL have port reset_count, output, 8 bits: number of accepted soft resets, saturating.

Function
REQ-013 The block SHALL run a single FSM with states ASSERT, RELEASE and RUN.
REQ-014 reset_n SHALL pass through a SYNC_STAGES-deep synchronizer that asserts asynchronously and deasserts synchronously.
REQ-015 T0 SHALL be defined as the first rising edge at which the synchronized reset is inactive and ext_hold is 0.
REQ-016 In ASSERT, a 16-bit hold counter SHALL increment from 0 each cycle, starting at T0.
REQ-017 The FSM SHALL move to RELEASE and drive rst_n_out[0] high at edge T0+HOLD_CYCLES.
REQ-018 rst_n_out[k] SHALL go high at edge T0+HOLD_CYCLES+k*STAGE_GAP, using an 8-bit gap counter and a domain index.
REQ-019 Released domains SHALL stay high; release order SHALL be strictly ascending index.
REQ-020 One cycle after rst_n_out[NUM_DOMAINS-1] rises, the FSM SHALL enter RUN and all_ready SHALL go high.
REQ-021 When NUM_DOMAINS=1, all_ready SHALL rise at T0+HOLD_CYCLES+1.
REQ-022 On soft_req=1 in RUN or RELEASE, at the next edge: all rst_n_out=0, all_ready=0, state=ASSERT, hold counter=0, reset_count incremented.
REQ-023 On soft_req=1 in ASSERT, the hold counter SHALL be cleared to 0 and reset_count SHALL NOT change.
REQ-024 soft_req held high SHALL keep the sequencer in ASSERT with the counter at 0; the new T0 is the first edge with soft_req=0 and ext_hold=0.
REQ-025 When ext_hold=1 in any state, at the next edge: all rst_n_out=0, state=ASSERT, hold counter held at 0, reset_count unchanged.
REQ-026 When ext_hold and soft_req are both 1 in RUN or RELEASE, the block SHALL apply REQ-022 and count the soft reset once.
REQ-027 reset_count SHALL saturate at 255; it SHALL be cleared only by reset_n.
REQ-028 busy SHALL equal (state != RUN), registered with state.

Reset
REQ-029 While reset_n=0, asynchronously: rst_n_out all 0, all_ready=0, busy=1, state=ASSERT, all counters 0, reset_count=0, synchronizer flops 0.
REQ-030 reset_n asserted mid-RELEASE or mid-RUN SHALL immediately re-assert every domain, with no glitch-high on any rst_n_out.
REQ-031 After reset_n deasserts, T0 SHALL occur SYNC_STAGES rising edges later, provided ext_hold=0.

Verification
REQ-032 Defaults; reset_n low 14 cycles then high; ext_hold=0 -> T0 2 edges after deassert; rst_n_out[0] at T0+14, [1] at T0+18, [2] at T0+22; all_ready at T0+23; reset_count=0.
REQ-033 In RUN, 1-cycle soft_req pulse -> next edge rst_n_out=3'b000, busy=1, reset_count=1; release replays with T0 = edge after pulse.
REQ-034 soft_req pulse 2 cycles after rst_n_out[0] rises -> all domains re-asserted next edge; domain 1 never rises; reset_count=1.
REQ-035 ext_hold high for 50 cycles from T0+10 -> outputs stay 0; release begins 14 cycles after ext_hold falls; reset_count unchanged.
REQ-036 300 soft_req pulses, each in RUN -> reset_count stops at 255; async reset_n pulse mid-RELEASE -> outputs 0 within the same cycle and reset_count=0.

Source files
------------

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: synchronizes reset_n, holds all domains in reset,
// then releases them one at a time in ascending order.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 3,
    parameter int HOLD_CYCLES = 14,
    parameter int STAGE_GAP   = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   soft_req,
    input  logic                   ext_hold,
    output logic [NUM_DOMAINS-1:0] rst_n_out,
    output logic                   all_ready,
    output logic                   busy,
    output logic [7:0]             reset_count
);

    localparam int DW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [DW-1:0]          LAST_DOM  = DW'(NUM_DOMAINS - 1);
    localparam logic [15:0]            HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [7:0]             GAP_LAST  = 8'(STAGE_GAP - 1);
    localparam logic [NUM_DOMAINS-1:0] DOM0      = NUM_DOMAINS'(1);

    typedef enum logic [1:0] {
        S_ASSERT  = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d;
    logic                   ready_q, ready_d;
    logic [15:0]            hold_q, hold_d;
    logic [7:0]             gap_q, gap_d;
    logic [DW-1:0]          dom_q, dom_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   armed_q, armed_d;
    logic                   rst_sync_n;
    logic                   disturb;
    logic                   counted;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_sync_n = sync_q[SYNC_STAGES-1];
    assign disturb    = soft_req | ext_hold;
    assign counted    = soft_req && (state_q != S_ASSERT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_ASSERT;
            rst_q   <= '0;
            ready_q <= 1'b0;
            hold_q  <= '0;
            gap_q   <= '0;
            dom_q   <= '0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            dom_q   <= dom_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    // armed_q marks that the previous edge was undisturbed; that edge is T0
    // and the hold counter starts advancing on the edge after it.
    always_comb begin
        state_d = state_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        dom_d   = dom_q;
        cnt_d   = cnt_q;
        armed_d = !disturb;
        if (disturb) begin
            state_d = S_ASSERT;
            rst_d   = '0;
            ready_d = 1'b0;
            hold_d  = '0;
            gap_d   = '0;
            dom_d   = '0;
            if (counted && (cnt_q != 8'hFF)) begin
                cnt_d = cnt_q + 8'd1;
            end
        end else begin
            unique case (state_q)
                S_ASSERT: begin
                    if (rst_sync_n && armed_q) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = S_RELEASE;
                            rst_d   = DOM0;
                            hold_d  = '0;
                            gap_d   = '0;
                            dom_d   = '0;
                        end else begin
                            hold_d = hold_q + 16'd1;
                        end
                    end
                end
                S_RELEASE: begin
                    if (dom_q == LAST_DOM) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                    end else if (gap_q == GAP_LAST) begin
                        gap_d = '0;
                        dom_d = dom_q + DW'(1);
                        rst_d = (rst_q << 1) | DOM0;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end
                S_RUN: begin
                    state_d = S_RUN;
                end
                default: begin
                    state_d = S_ASSERT;
                end
            endcase
        end
    end

    assign rst_n_out   = rst_q;
    assign all_ready   = ready_q;
    assign busy        = (state_q != S_RUN);
    assign reset_count = cnt_q;

endmodule
